// File: rtl/spi_pkg.sv
// Shared SPI-controller command encoding.
package spi_pkg;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_ERASE = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_END   = 2'd3
  } cmd_t;

endpackage

// File: rtl/stream_pkg.sv
// Types for the UART-to-flash stream scheduler.
package stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ERASE  = 3'd1,
    ST_WRITE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FINISH = 3'd4,
    ST_DONE   = 3'd5
  } sched_state_t;

  typedef enum logic {
    BUF_FREE = 1'b0,
    BUF_FULL = 1'b1
  } buf_state_t;

endpackage

// File: rtl/flash_stream_sched_pingpong_track.sv
// Ownership tracker for two ping-pong block buffers.
//   claim_req     : producer event (wr_full or wr_last) this cycle
//   claim_len     : bytes to commit to the fill buffer; 0 commits nothing
//   drain_release : consumer finished the drain buffer
//   fill_sel/drain_sel : buffer indices for producer / consumer
//   fill_ready    : fill buffer is FREE
//   overrun       : sticky, producer event while fill_ready=0
//   drain_full/drain_len : state and stored length of the drain buffer
module pingpong_track
  import stream_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = 256,
  localparam int unsigned LW = $clog2(BLOCK_SIZE) + 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          claim_req,
  input  logic [LW-1:0] claim_len,
  input  logic          drain_release,
  output logic          fill_sel,
  output logic          drain_sel,
  output logic          fill_ready,
  output logic          overrun,
  output logic          drain_full,
  output logic [LW-1:0] drain_len
);

  buf_state_t [1:0]          buf_st_q, buf_st_d;
  logic       [1:0][LW-1:0]  buf_len_q, buf_len_d;
  logic                      fill_sel_q, fill_sel_d;
  logic                      drain_sel_q, drain_sel_d;
  logic                      overrun_q, overrun_d;

  // Release and claim always target different buffers (FULL vs FREE),
  // so both can be applied in the same cycle.
  always_comb begin
    buf_st_d    = buf_st_q;
    buf_len_d   = buf_len_q;
    fill_sel_d  = fill_sel_q;
    drain_sel_d = drain_sel_q;
    overrun_d   = overrun_q;
    if (drain_release) begin
      buf_st_d[drain_sel_q] = BUF_FREE;
      drain_sel_d           = ~drain_sel_q;
    end
    if (claim_req) begin
      if (!fill_ready) begin
        overrun_d = 1'b1;
      end else if (claim_len != '0) begin
        buf_st_d[fill_sel_q]  = BUF_FULL;
        buf_len_d[fill_sel_q] = claim_len;
        fill_sel_d            = ~fill_sel_q;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      buf_st_q[0]  <= BUF_FREE;
      buf_st_q[1]  <= BUF_FREE;
      buf_len_q    <= '0;
      fill_sel_q   <= 1'b0;
      drain_sel_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      buf_st_q     <= buf_st_d;
      buf_len_q    <= buf_len_d;
      fill_sel_q   <= fill_sel_d;
      drain_sel_q  <= drain_sel_d;
      overrun_q    <= overrun_d;
    end
  end

  assign fill_sel   = fill_sel_q;
  assign drain_sel  = drain_sel_q;
  assign fill_ready = (buf_st_q[fill_sel_q] == BUF_FREE);
  assign overrun    = overrun_q;
  assign drain_full = (buf_st_q[drain_sel_q] == BUF_FULL);
  assign drain_len  = buf_len_q[drain_sel_q];

endmodule

// File: rtl/flash_stream_sched.sv
// Schedules ERASE/WRITE/END commands to the SPI flash controller from two
// ping-pong buffers filled by the UART producer.
//   wr_full/wr_last/wr_count : producer strobes and final partial count
//   fill_sel/fill_ready      : producer buffer and its availability
//   drain_sel                : buffer read by the SPI controller
//   cmd/cmd_valid/cmd_addr/cmd_len/cmd_done : one-in-flight command handshake
//   overrun                  : sticky producer overrun
//   done                     : END command completed
module flash_stream_sched
  import spi_pkg::*;
  import stream_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE  = 256,
  parameter int unsigned SECTOR_SIZE = 65536,
  parameter logic [23:0] BASE_ADDR   = 24'h000000,
  localparam int unsigned LW = $clog2(BLOCK_SIZE) + 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          wr_full,
  input  logic          wr_last,
  input  logic [LW-1:0] wr_count,
  output logic          fill_sel,
  output logic          fill_ready,
  output logic          drain_sel,
  output cmd_t          cmd,
  output logic          cmd_valid,
  output logic [23:0]   cmd_addr,
  output logic [LW-1:0] cmd_len,
  input  logic          cmd_done,
  output logic          overrun,
  output logic          done
);

  localparam logic [23:0]   SECTOR_MASK = 24'(SECTOR_SIZE - 1);
  localparam logic [23:0]   BLOCK_STEP  = 24'(BLOCK_SIZE);
  localparam logic [LW-1:0] BLOCK_LEN   = LW'(BLOCK_SIZE);

  sched_state_t  state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [23:0]   cmd_addr_q, cmd_addr_d;
  logic [LW-1:0] cmd_len_q, cmd_len_d;
  logic          done_q, done_d;
  logic [23:0]   next_addr_q, next_addr_d;
  logic [23:0]   erased_q, erased_d;
  logic          erased_vld_q, erased_vld_d;
  logic          stream_end_q, stream_end_d;

  logic          accept_wr;
  logic          claim_req;
  logic [LW-1:0] claim_len;
  logic          drain_release;
  logic          drain_full;
  logic [LW-1:0] drain_len;
  logic          need_erase;

  // Producer strobes are ignored once the stream has completed.
  assign accept_wr = (state_q != ST_DONE);
  assign claim_req = accept_wr && (wr_full || wr_last);
  assign claim_len = wr_full ? BLOCK_LEN : wr_count;

  pingpong_track #(
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_track (
    .clk           (clk),
    .n_rst         (n_rst),
    .claim_req     (claim_req),
    .claim_len     (claim_len),
    .drain_release (drain_release),
    .fill_sel      (fill_sel),
    .drain_sel     (drain_sel),
    .fill_ready    (fill_ready),
    .overrun       (overrun),
    .drain_full    (drain_full),
    .drain_len     (drain_len)
  );

  // The valid flag keeps the very first sector from matching a stale record.
  assign need_erase = ((next_addr_q & SECTOR_MASK) == '0) &&
                      !(erased_vld_q && (erased_q == next_addr_q));

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_len_d     = cmd_len_q;
    done_d        = done_q;
    next_addr_d   = next_addr_q;
    erased_d      = erased_q;
    erased_vld_d  = erased_vld_q;
    stream_end_d  = stream_end_q || (accept_wr && wr_last);
    drain_release = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (drain_full) begin
          state_d = need_erase ? ST_ERASE : ST_WRITE;
        end else if (stream_end_q) begin
          state_d = ST_FINISH;
        end
      end
      ST_ERASE: begin
        cmd_d       = CMD_ERASE;
        cmd_addr_d  = next_addr_q;
        cmd_len_d   = '0;
        cmd_valid_d = 1'b1;
        state_d     = ST_WAIT;
      end
      ST_WRITE: begin
        cmd_d       = CMD_WRITE;
        cmd_addr_d  = next_addr_q;
        cmd_len_d   = drain_len;
        cmd_valid_d = 1'b1;
        state_d     = ST_WAIT;
      end
      ST_FINISH: begin
        cmd_d       = CMD_END;
        cmd_addr_d  = next_addr_q;
        cmd_len_d   = '0;
        cmd_valid_d = 1'b1;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (cmd_done) begin
          cmd_d       = CMD_NONE;
          cmd_len_d   = '0;
          cmd_valid_d = 1'b0;
          state_d     = ST_IDLE;
          unique case (cmd_q)
            CMD_ERASE: begin
              erased_d     = next_addr_q;
              erased_vld_d = 1'b1;
            end
            CMD_WRITE: begin
              drain_release = 1'b1;
              next_addr_d   = next_addr_q + BLOCK_STEP;
            end
            CMD_END: begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
            default: ;
          endcase
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      cmd_q        <= CMD_NONE;
      cmd_valid_q  <= 1'b0;
      cmd_addr_q   <= BASE_ADDR;
      cmd_len_q    <= '0;
      done_q       <= 1'b0;
      next_addr_q  <= BASE_ADDR;
      erased_q     <= '0;
      erased_vld_q <= 1'b0;
      stream_end_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_len_q    <= cmd_len_d;
      done_q       <= done_d;
      next_addr_q  <= next_addr_d;
      erased_q     <= erased_d;
      erased_vld_q <= erased_vld_d;
      stream_end_q <= stream_end_d;
    end
  end

  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_len   = cmd_len_q;
  assign done      = done_q;

endmodule

// File: tb/tb_flash_stream_sched.sv
// Scoreboard bench for flash_stream_sched: expected commands are queued when
// producer strobes are driven, and checked as the DUT issues them.
module tb_flash_stream_sched;
  import spi_pkg::*;

  typedef struct packed {
    cmd_t        cmd;
    logic [23:0] addr;
    logic [8:0]  len;
  } exp_t;

  logic        clk;
  logic        n_rst;
  logic        wr_full;
  logic        wr_last;
  logic [8:0]  wr_count;
  logic        fill_sel;
  logic        fill_ready;
  logic        drain_sel;
  cmd_t        cmd;
  logic        cmd_valid;
  logic [23:0] cmd_addr;
  logic [8:0]  cmd_len;
  logic        cmd_done;
  logic        overrun;
  logic        done;

  flash_stream_sched #(
    .BLOCK_SIZE  (256),
    .SECTOR_SIZE (65536),
    .BASE_ADDR   (24'h000000)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .wr_full    (wr_full),
    .wr_last    (wr_last),
    .wr_count   (wr_count),
    .fill_sel   (fill_sel),
    .fill_ready (fill_ready),
    .drain_sel  (drain_sel),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_done   (cmd_done),
    .overrun    (overrun),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        exp_q[$];
  exp_t        cur;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  bit          busy         = 0;
  bit          drop_pending = 0;
  bit          hold_done    = 0;
  int unsigned done_delay   = 5;
  int unsigned waitc        = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic exp_t mk(input cmd_t c, input logic [23:0] a, input logic [8:0] l);
    exp_t e;
    e.cmd  = c;
    e.addr = a;
    e.len  = l;
    return e;
  endfunction

  // SPI controller model: pops the expected command on first sight of
  // cmd_valid, checks stability, and answers with cmd_done after done_delay.
  initial begin : spi_model
    cmd_done = 1'b0;
    forever begin
      @(negedge clk);
      cmd_done = 1'b0;
      if (!n_rst) begin
        busy         = 0;
        drop_pending = 0;
      end else if (drop_pending) begin
        check_eq("valid_drop", cmd_valid, 0);
        drop_pending = 0;
        busy         = 0;
      end else if (cmd_valid && !busy) begin
        check_eq("cmd_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          check_eq("cmd", cmd, cur.cmd);
          check_eq("cmd_len", cmd_len, cur.len);
          if (cur.cmd != CMD_END) check_eq("cmd_addr", cmd_addr, cur.addr);
          busy  = 1;
          waitc = 0;
        end
      end else if (cmd_valid && busy) begin
        check_eq("cmd_stable", cmd, cur.cmd);
        check_eq("len_stable", cmd_len, cur.len);
        if (cur.cmd != CMD_END) check_eq("addr_stable", cmd_addr, cur.addr);
        waitc++;
        if (!hold_done && waitc >= done_delay) begin
          cmd_done     = 1'b1;
          drop_pending = 1;
        end
      end
    end
  end

  task automatic do_reset();
    n_rst     = 1'b0;
    wr_full   = 1'b0;
    wr_last   = 1'b0;
    wr_count  = '0;
    hold_done = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_full();
    wr_full = 1'b1;
    @(negedge clk);
    wr_full = 1'b0;
  endtask

  task automatic pulse_last(input logic [8:0] cnt);
    wr_last  = 1'b1;
    wr_count = cnt;
    @(negedge clk);
    wr_last  = 1'b0;
    wr_count = '0;
  endtask

  task automatic wait_ready(input string tag);
    int unsigned n = 0;
    while (!fill_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_ready"}, fill_ready, 1);
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !busy && !drop_pending && !cmd_valid) break;
      @(negedge clk);
    end
    @(negedge clk);
    check_eq({tag, "_drained"}, exp_q.size(), 0);
    check_eq({tag, "_idle"}, cmd_valid, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_fill_sel"},   fill_sel, 0);
    check_eq({tag, "_drain_sel"},  drain_sel, 0);
    check_eq({tag, "_fill_ready"}, fill_ready, 1);
    check_eq({tag, "_cmd"},        cmd, CMD_NONE);
    check_eq({tag, "_cmd_valid"},  cmd_valid, 0);
    check_eq({tag, "_cmd_addr"},   cmd_addr, 24'h000000);
    check_eq({tag, "_cmd_len"},    cmd_len, 0);
    check_eq({tag, "_overrun"},    overrun, 0);
    check_eq({tag, "_done"},       done, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin : main
    logic [23:0] a;
    int unsigned n;

    // Single block: ERASE then WRITE, two-edge latency
    do_reset();
    check_reset_vals("rst");
    done_delay = 5;
    exp_q.push_back(mk(CMD_ERASE, 24'h000000, 9'd0));
    exp_q.push_back(mk(CMD_WRITE, 24'h000000, 9'd256));
    pulse_full();
    check_eq("lat_n", cmd_valid, 0);
    @(negedge clk);
    check_eq("lat_n1", cmd_valid, 0);
    @(negedge clk);
    check_eq("lat_n2", cmd_valid, 1);
    wait_idle("one", 200);
    check_eq("one_drain_sel", drain_sel, 1);
    check_eq("one_fill_ready", fill_ready, 1);
    check_eq("one_fill_sel", fill_sel, 1);

    // 257 consecutive blocks across a sector boundary
    do_reset();
    done_delay = 1;
    for (int unsigned i = 0; i < 257; i++) begin
      a = 24'(i * 256);
      if (a[15:0] == 16'h0000) exp_q.push_back(mk(CMD_ERASE, a, 9'd0));
      exp_q.push_back(mk(CMD_WRITE, a, 9'd256));
      wait_ready("stream");
      pulse_full();
    end
    wait_idle("stream", 500);

    // Overrun: both buffers full while the controller stalls
    do_reset();
    done_delay = 2;
    hold_done  = 1;
    exp_q.push_back(mk(CMD_ERASE, 24'h000000, 9'd0));
    exp_q.push_back(mk(CMD_WRITE, 24'h000000, 9'd256));
    exp_q.push_back(mk(CMD_WRITE, 24'h000100, 9'd256));
    pulse_full();
    pulse_full();
    check_eq("ovr_not_ready", fill_ready, 0);
    check_eq("ovr_clear", overrun, 0);
    pulse_full();
    check_eq("ovr_set", overrun, 1);
    check_eq("ovr_still_not_ready", fill_ready, 0);
    repeat (5) @(negedge clk);
    hold_done = 0;
    wait_idle("ovr", 200);
    check_eq("ovr_ready_after", fill_ready, 1);
    check_eq("ovr_sticky", overrun, 1);
    exp_q.push_back(mk(CMD_END, 24'h000000, 9'd0));
    pulse_last(9'd0);
    wait_idle("ovr_end", 200);
    check_eq("ovr_done", done, 1);

    // Two full blocks then a partial last block
    do_reset();
    done_delay = 3;
    exp_q.push_back(mk(CMD_ERASE, 24'h000000, 9'd0));
    exp_q.push_back(mk(CMD_WRITE, 24'h000000, 9'd256));
    pulse_full();
    exp_q.push_back(mk(CMD_WRITE, 24'h000100, 9'd256));
    wait_ready("part1");
    pulse_full();
    exp_q.push_back(mk(CMD_WRITE, 24'h000200, 9'd37));
    exp_q.push_back(mk(CMD_END, 24'h000000, 9'd0));
    wait_ready("part2");
    pulse_last(9'd37);
    check_eq("part_done_early", done, 0);
    wait_idle("part", 400);
    check_eq("part_done", done, 1);
    pulse_full();
    repeat (4) @(negedge clk);
    check_eq("done_ignores_wr", cmd_valid, 0);
    check_eq("done_holds", done, 1);
    check_eq("done_no_overrun", overrun, 0);

    // Empty stream end: END only
    do_reset();
    done_delay = 2;
    exp_q.push_back(mk(CMD_END, 24'h000000, 9'd0));
    pulse_last(9'd0);
    wait_idle("empty", 200);
    check_eq("empty_done", done, 1);

    // Asynchronous reset while a WRITE is outstanding
    do_reset();
    done_delay = 20;
    exp_q.push_back(mk(CMD_ERASE, 24'h000000, 9'd0));
    exp_q.push_back(mk(CMD_WRITE, 24'h000000, 9'd256));
    pulse_full();
    n = 0;
    while (!(cmd_valid && cmd == CMD_WRITE) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("arst_write_seen", cmd_valid && (cmd == CMD_WRITE), 1);
    #1;
    n_rst = 1'b0;
    #1;
    check_reset_vals("arst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    done_delay = 2;
    exp_q.push_back(mk(CMD_ERASE, 24'h000000, 9'd0));
    exp_q.push_back(mk(CMD_WRITE, 24'h000000, 9'd256));
    pulse_full();
    wait_idle("arst", 200);
    check_eq("arst_drain_sel", drain_sel, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/flash_stream_sched.md
Name: flash_stream_sched

Overview:
- Sequences streaming UART data into SPI flash through two ping-pong block buffers.
- Tracks ownership of each buffer between the UART producer and the SPI consumer.
- Issues ERASE and WRITE commands with address and length to the SPI controller, one command in flight at a time.
- Issues END once the stream finishes and every buffer has drained.

Parameters:
- BLOCK_SIZE, 256, bytes per buffer; one page-program per full buffer; power of two.
- SECTOR_SIZE, 65536, erase granularity in bytes; power of two, multiple of BLOCK_SIZE.
- BASE_ADDR, 24'h000000, first flash address written; SECTOR_SIZE-aligned.

Ports:
- clk  in  1  clock.
- n_rst  in  1  reset; asynchronous, active-low.
- wr_full  in  1  pulse: producer completed BLOCK_SIZE bytes into buffer fill_sel.
- wr_last  in  1  pulse: stream ended (UART timeout).
- wr_count  in  $clog2(BLOCK_SIZE)+1  bytes in current fill buffer; sampled only with wr_last.
- fill_sel  out  1  buffer the producer writes.
- fill_ready  out  1  buffer fill_sel is FREE.
- drain_sel  out  1  buffer the SPI controller reads.
- cmd  out  spi_pkg::cmd_t  NONE/ERASE/WRITE/END.
- cmd_valid  out  1  cmd, cmd_addr, cmd_len valid.
- cmd_addr  out  24  flash address.
- cmd_len  out  $clog2(BLOCK_SIZE)+1  bytes for WRITE; 0 otherwise.
- cmd_done  in  1  pulse: SPI controller finished the current command.
- overrun  out  1  sticky: wr_full/wr_last arrived while fill_ready=0.
- done  out  1  END command completed.

Behaviour:
- Reset values: fill_sel=0, drain_sel=0, fill_ready=1, cmd=NONE, cmd_valid=0, cmd_addr=BASE_ADDR, cmd_len=0, overrun=0, done=0. Both buffers FREE; next_addr=BASE_ADDR.
- Buffer state per buffer: FREE or FULL, with a stored length.
  - wr_full with fill_ready=1: mark fill_sel FULL with len=BLOCK_SIZE; toggle fill_sel on the next cycle.
  - wr_last: latch stream_end. If wr_count>0 and fill_ready=1, mark fill_sel FULL with len=wr_count. wr_count=0 marks nothing.
  - wr_full and wr_last in the same cycle: the full block is the last block with len=BLOCK_SIZE; wr_count is ignored.
  - wr_full or wr_last while fill_ready=0: set overrun; data is dropped; buffer state is unchanged.
- FSM states: IDLE, ERASE, WRITE, WAIT, FINISH, DONE.
  - IDLE, drain_sel FULL:
    - next_addr%SECTOR_SIZE==0 and next_addr != erased_sector -> ERASE.
    - otherwise -> WRITE.
  - IDLE, drain_sel FREE, stream_end set -> FINISH.
  - ERASE: cmd=ERASE, cmd_addr=next_addr, cmd_valid=1 -> WAIT. On completion, erased_sector=next_addr; return to IDLE.
  - WRITE: cmd=WRITE, cmd_addr=next_addr, cmd_len=stored len, cmd_valid=1 -> WAIT. On completion:
    - mark drain_sel FREE;
    - toggle drain_sel;
    - next_addr += BLOCK_SIZE, mod 2^24, wraps silently;
    - return to IDLE.
  - FINISH: cmd=END, cmd_valid=1 -> WAIT. On completion -> DONE.
  - DONE: done=1, cmd_valid=0, all wr_* ignored. Only reset exits.
- Latency: buffer becomes FULL at edge N -> cmd_valid=1 at edge N+2 (one IDLE decision cycle).
- Handshake:
  - cmd/cmd_addr/cmd_len are stable while cmd_valid=1.
  - cmd_valid drops the cycle after cmd_done.
  - cmd_done with cmd_valid=0 is ignored.
- Simultaneous events:
  - cmd_done freeing a buffer and wr_full on the other buffer in the same cycle are both processed.
  - fill_ready is recomputed from the post-update states.
- fill_ready=FREE(fill_sel). The producer must stall when it is 0.
- Reset mid-command: all state returns to reset values. The SPI controller is reset by the same n_rst.

Decomposition:
- spi_pkg: cmd_t, already shared.
- New stream_pkg: sched_state_t enum, buf_state_t (FREE/FULL).
- Sub-module pingpong_track: two buffer states and lengths, fill_sel/drain_sel, fill_ready, overrun. Ports are claim/release strobes.
- The FSM and address counter stay in flash_stream_sched.

Test Plan:
- Reset, one wr_full, cmd_done after 5 cycles.
  - ERASE@0x000000, then WRITE@0x000000 len=256.
  - Then drain_sel=1, fill_ready=1.
- 257 consecutive blocks.
  - ERASE at 0x000000 and 0x010000 only.
  - WRITE addresses step 0x100; the last WRITE is @0x010000.
- wr_full at both buffers with cmd_done withheld, then a third wr_full.
  - fill_ready=0 and overrun=1.
  - The third block is not written.
- Two full blocks, then wr_last with wr_count=37.
  - Third WRITE len=37 @0x000200.
  - Then END; done=1 after its cmd_done.
- wr_last with wr_count=0 and no pending data.
  - END is issued directly; no WRITE, no ERASE.
- n_rst asserted while WRITE cmd_valid=1.
  - All outputs return to reset values asynchronously.
  - After release, the next wr_full writes @BASE_ADDR preceded by ERASE.
